// File: rtl/memctl.sv
// Memory bus controller: runs one processor read, write or read-modify-write
// cycle on the memory bus, aborting with a sticky NXM flag on a missing acknowledge.
module memctl #(
    parameter int TIMEOUT  = 1000,
    parameter int WR_SETUP = 4,
    parameter int WRRS_LEN = 2,
    parameter bit FMC_EN   = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rq_rd,
    input  logic          rq_wr,
    input  logic [18:35]  rq_addr,
    input  logic [0:35]   wr_data,
    input  logic          wr_go,
    output logic          busy,
    output logic          rd_valid,
    output logic [0:35]   rd_data,
    output logic          done,
    output logic          nxm,
    output logic          mc_rq_cyc,
    output logic          mc_rd_rq,
    output logic          mc_wr_rq,
    output logic          mc_wr_rs,
    output logic [21:35]  ma,
    output logic [18:21]  sel,
    output logic          fmc_select,
    output logic [0:35]   mb_out,
    input  logic          cmc_addr_ack,
    input  logic          cmc_rd_rs,
    input  logic [0:35]   mb_in
);

    // state    | meaning
    // ---------+----------------------------------------------------------
    // IDLE     | no cycle; waits for rq_rd/rq_wr
    // ADDR     | mc_rq_cyc asserted, waiting for cmc_addr_ack (timed)
    // RDWAIT   | accumulating mb_in, waiting for cmc_rd_rs (timed)
    // RMWHOLD  | read half of RMW done, waiting for wr_go (untimed)
    // WRDATA   | write data set up on mb_out for WR_SETUP cycles
    // WRRS     | mc_wr_rs pulse for WRRS_LEN cycles
    // DONE     | one-cycle done pulse, bus requests dropped
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RDWAIT,
        S_RMWHOLD,
        S_WRDATA,
        S_WRRS,
        S_DONE
    } state_t;

    localparam int CNT_MAX = (TIMEOUT > WR_SETUP)
                           ? ((TIMEOUT > WRRS_LEN) ? TIMEOUT : WRRS_LEN)
                           : ((WR_SETUP > WRRS_LEN) ? WR_SETUP : WRRS_LEN);
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] LD_TIMEOUT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] LD_SETUP   = CW'(WR_SETUP - 1);
    localparam logic [CW-1:0] LD_WRRS    = CW'(WRRS_LEN - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [18:35]    addr_q;
    logic            is_rd, is_wr;
    logic [0:35]     wdata_q;
    logic            set_nxm;
    logic            rs_seen;
    logic            start;
    logic            cnt_tc;

    assign start  = (state == S_IDLE) && (rq_rd || rq_wr);
    assign cnt_tc = (cnt == '0);

    // Single down-counter shared by the timeout, setup and restart-width timers;
    // it is reloaded on each entry to a timed state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_tc ? cnt : cnt - CW'(1);
        set_nxm   = 1'b0;
        rs_seen   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ADDR;
                    cnt_nxt   = LD_TIMEOUT;
                end
            end
            S_ADDR: begin
                if (cmc_addr_ack) begin
                    if (is_rd) begin
                        state_nxt = S_RDWAIT;
                        cnt_nxt   = LD_TIMEOUT;
                    end else begin
                        state_nxt = S_WRDATA;
                        cnt_nxt   = LD_SETUP;
                    end
                end else if (cnt_tc) begin
                    state_nxt = S_DONE;
                    set_nxm   = 1'b1;
                end
            end
            S_RDWAIT: begin
                if (cmc_rd_rs) begin
                    rs_seen   = 1'b1;
                    state_nxt = is_wr ? S_RMWHOLD : S_DONE;
                end else if (cnt_tc) begin
                    state_nxt = S_DONE;
                    set_nxm   = 1'b1;
                end
            end
            S_RMWHOLD: begin
                if (wr_go) begin
                    state_nxt = S_WRDATA;
                    cnt_nxt   = LD_SETUP;
                end
            end
            S_WRDATA: begin
                if (cnt_tc) begin
                    state_nxt = S_WRRS;
                    cnt_nxt   = LD_WRRS;
                end
            end
            S_WRRS: begin
                if (cnt_tc) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rd_valid <= rs_seen;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            is_rd   <= 1'b0;
            is_wr   <= 1'b0;
            wdata_q <= '0;
            rd_data <= '0;
            nxm     <= 1'b0;
        end else begin
            if (start) begin
                addr_q  <= rq_addr;
                is_rd   <= rq_rd;
                is_wr   <= rq_wr;
                rd_data <= '0;
                nxm     <= 1'b0;
                if (rq_wr && !rq_rd) begin
                    wdata_q <= wr_data;
                end
            end
            // Memory data is only valid briefly, so every RDWAIT cycle is merged in.
            if (state == S_RDWAIT) begin
                rd_data <= rd_data | mb_in;
            end
            if (set_nxm) begin
                nxm <= 1'b1;
            end
            if ((state == S_RMWHOLD) && wr_go) begin
                wdata_q <= wr_data;
            end
        end
    end

    logic bus_active;
    logic wr_phase;

    assign bus_active = (state == S_ADDR) || (state == S_RDWAIT) || (state == S_RMWHOLD)
                     || (state == S_WRDATA) || (state == S_WRRS);
    assign wr_phase   = (state == S_WRDATA) || (state == S_WRRS);

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign mc_rq_cyc  = (state == S_ADDR);
    assign mc_rd_rq   = bus_active && is_rd;
    assign mc_wr_rq   = bus_active && is_wr;
    assign mc_wr_rs   = (state == S_WRRS);
    assign mb_out     = wr_phase ? wdata_q : '0;
    assign ma         = busy ? addr_q[21:35] : '0;
    assign sel        = busy ? addr_q[18:21] : '0;
    assign fmc_select = busy && FMC_EN && (addr_q[18:31] == 14'd0);

endmodule

// File: tb/tb_memctl.sv
// Directed bench for memctl: read, write, RMW, NXM timeouts, ack-at-timeout
// and asynchronous reset in the middle of a write.
module tb_memctl;
    localparam int TIMEOUT  = 1000;
    localparam int WR_SETUP = 4;
    localparam int WRRS_LEN = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          rq_rd = 1'b0;
    logic          rq_wr = 1'b0;
    logic [18:35]  rq_addr = '0;
    logic [0:35]   wr_data = '0;
    logic          wr_go = 1'b0;
    logic          busy, rd_valid, done, nxm;
    logic [0:35]   rd_data;
    logic          mc_rq_cyc, mc_rd_rq, mc_wr_rq, mc_wr_rs;
    logic [21:35]  ma;
    logic [18:21]  sel;
    logic          fmc_select;
    logic [0:35]   mb_out;
    logic          cmc_addr_ack = 1'b0;
    logic          cmc_rd_rs = 1'b0;
    logic [0:35]   mb_in = '0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rv_cnt = 0;
    int wrrs_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge done) done_cnt++;
    always @(posedge rd_valid) rv_cnt++;
    always @(posedge mc_wr_rs) wrrs_cnt++;

    memctl #(
        .TIMEOUT(TIMEOUT),
        .WR_SETUP(WR_SETUP),
        .WRRS_LEN(WRRS_LEN),
        .FMC_EN(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rq_rd(rq_rd),
        .rq_wr(rq_wr),
        .rq_addr(rq_addr),
        .wr_data(wr_data),
        .wr_go(wr_go),
        .busy(busy),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .done(done),
        .nxm(nxm),
        .mc_rq_cyc(mc_rq_cyc),
        .mc_rd_rq(mc_rd_rq),
        .mc_wr_rq(mc_wr_rq),
        .mc_wr_rs(mc_wr_rs),
        .ma(ma),
        .sel(sel),
        .fmc_select(fmc_select),
        .mb_out(mb_out),
        .cmc_addr_ack(cmc_addr_ack),
        .cmc_rd_rs(cmc_rd_rs),
        .mb_in(mb_in)
    );

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        nclk(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({rd_valid, done, nxm, mc_rq_cyc, mc_rd_rq, mc_wr_rq, mc_wr_rs, fmc_select} !== 8'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000000", {rd_valid, done, nxm, mc_rq_cyc, mc_rd_rq, mc_wr_rq, mc_wr_rs, fmc_select}); end
        checks++; if ({rd_data, mb_out} !== 72'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", {rd_data, mb_out}); end
        checks++; if ({ma, sel} !== 19'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", {ma, sel}); end
        reset_n = 1'b1;
        nclk(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b expected 0", busy); end
    endtask

    task automatic test_read();
        int d0, v0;
        d0 = done_cnt; v0 = rv_cnt;
        rq_rd = 1'b1; rq_addr = 18'o001234; mb_in = 36'o7;
        nclk(1);
        rq_rd = 1'b0;
        checks++; if ({busy, mc_rq_cyc, mc_rd_rq, mc_wr_rq} !== 4'b1110) begin errors++; $display("FAIL read_addr_req: got %b expected 1110", {busy, mc_rq_cyc, mc_rd_rq, mc_wr_rq}); end
        checks++; if ({ma, sel, fmc_select} !== {15'o01234, 4'd0, 1'b0}) begin errors++; $display("FAIL read_addr: got %h expected %h", {ma, sel, fmc_select}, {15'o01234, 4'd0, 1'b0}); end
        nclk(2);
        cmc_addr_ack = 1'b1;
        checks++; if (mc_rq_cyc !== 1'b1) begin errors++; $display("FAIL read_wait_ack: got %b expected 1", mc_rq_cyc); end
        nclk(1);
        cmc_addr_ack = 1'b0; mb_in = '0;
        checks++; if ({mc_rq_cyc, mc_rd_rq, ma} !== {1'b0, 1'b1, 15'o01234}) begin errors++; $display("FAIL read_rdwait: got %h expected %h", {mc_rq_cyc, mc_rd_rq, ma}, {1'b0, 1'b1, 15'o01234}); end
        nclk(9);
        cmc_rd_rs = 1'b1; mb_in = 36'o123456654321;
        nclk(1);
        cmc_rd_rs = 1'b0; mb_in = 36'o7;
        checks++; if ({rd_valid, done, nxm, mc_rd_rq} !== 4'b1100) begin errors++; $display("FAIL read_done_flags: got %b expected 1100", {rd_valid, done, nxm, mc_rd_rq}); end
        checks++; if (rd_data !== 36'o123456654321) begin errors++; $display("FAIL read_data: got %o expected 123456654321", rd_data); end
        nclk(1);
        mb_in = '0;
        checks++; if ({busy, rd_valid, done, ma} !== 18'd0) begin errors++; $display("FAIL read_idle: got %h expected 0", {busy, rd_valid, done, ma}); end
        checks++; if (rd_data !== 36'o123456654321) begin errors++; $display("FAIL read_data_hold: got %o expected 123456654321", rd_data); end
        checks++; if ({done_cnt - d0, rv_cnt - v0} !== {32'd1, 32'd1}) begin errors++; $display("FAIL read_pulse_counts: got done %0d valid %0d expected 1 1", done_cnt - d0, rv_cnt - v0); end
    endtask

    task automatic test_read_or();
        rq_rd = 1'b1; rq_addr = 18'o000005; cmc_addr_ack = 1'b1;
        nclk(1);
        rq_rd = 1'b0;
        checks++; if (rd_data !== 36'd0) begin errors++; $display("FAIL or_clear: got %o expected 0", rd_data); end
        checks++; if ({fmc_select, sel, ma} !== {1'b1, 4'd0, 15'o5}) begin errors++; $display("FAIL or_fmc: got %h expected %h", {fmc_select, sel, ma}, {1'b1, 4'd0, 15'o5}); end
        nclk(1);
        cmc_addr_ack = 1'b0; mb_in = 36'o400000000001;
        nclk(1);
        mb_in = 36'o000000000002; cmc_rd_rs = 1'b1;
        nclk(1);
        mb_in = '0; cmc_rd_rs = 1'b0;
        checks++; if ({rd_valid, done} !== 2'b11) begin errors++; $display("FAIL or_done: got %b expected 11", {rd_valid, done}); end
        checks++; if (rd_data !== 36'o400000000003) begin errors++; $display("FAIL or_data: got %o expected 400000000003", rd_data); end
        nclk(1);
    endtask

    task automatic test_write();
        logic [0:35] wd;
        int d0, v0;
        wd = 36'o777000111222;
        d0 = done_cnt; v0 = rv_cnt;
        rq_wr = 1'b1; rq_addr = 18'o040100; wr_data = wd; cmc_addr_ack = 1'b1;
        nclk(1);
        rq_wr = 1'b0; wr_data = 36'o5;
        checks++; if ({mc_rq_cyc, mc_rd_rq, mc_wr_rq, mc_wr_rs} !== 4'b1010) begin errors++; $display("FAIL wr_addr_req: got %b expected 1010", {mc_rq_cyc, mc_rd_rq, mc_wr_rq, mc_wr_rs}); end
        checks++; if ({sel, ma, fmc_select} !== {4'd1, 15'o40100, 1'b0}) begin errors++; $display("FAIL wr_addr: got %h expected %h", {sel, ma, fmc_select}, {4'd1, 15'o40100, 1'b0}); end
        checks++; if ({mb_out, rd_data} !== 72'd0) begin errors++; $display("FAIL wr_addr_data: got %h expected 0", {mb_out, rd_data}); end
        nclk(1);
        for (int i = 2; i <= 7; i++) begin
            if (i == 2) cmc_addr_ack = 1'b0;
            if (i == 3) begin rq_rd = 1'b1; cmc_rd_rs = 1'b1; mb_in = '1; end
            if (i == 4) begin rq_rd = 1'b0; cmc_rd_rs = 1'b0; mb_in = '0; end
            checks++; if ({mc_wr_rs, mc_wr_rq, mc_rq_cyc, mb_out} !== {(i >= 6), 1'b1, 1'b0, wd}) begin errors++; $display("FAIL wr_phase_%0d: got %h expected %h", i, {mc_wr_rs, mc_wr_rq, mc_rq_cyc, mb_out}, {(i >= 6), 1'b1, 1'b0, wd}); end
            nclk(1);
        end
        checks++; if ({done, mc_wr_rs, mc_wr_rq, mb_out} !== {3'b100, 36'd0}) begin errors++; $display("FAIL wr_done: got %h expected %h", {done, mc_wr_rs, mc_wr_rq, mb_out}, {3'b100, 36'd0}); end
        nclk(1);
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL wr_idle: got %b expected 00", {busy, done}); end
        nclk(1);
        checks++; if ({busy, rd_data} !== 37'd0) begin errors++; $display("FAIL wr_no_queue: got %h expected 0", {busy, rd_data}); end
        checks++; if ({done_cnt - d0, rv_cnt - v0} !== {32'd1, 32'd0}) begin errors++; $display("FAIL wr_pulse_counts: got done %0d valid %0d expected 1 0", done_cnt - d0, rv_cnt - v0); end
    endtask

    task automatic test_rmw();
        int d0, v0;
        d0 = done_cnt; v0 = rv_cnt;
        rq_rd = 1'b1; rq_wr = 1'b1; rq_addr = 18'o000020; wr_data = 36'o777;
        nclk(1);
        rq_rd = 1'b0; rq_wr = 1'b0; cmc_addr_ack = 1'b1;
        checks++; if ({mc_rq_cyc, mc_rd_rq, mc_wr_rq, fmc_select, ma, sel} !== {4'b1110, 15'o20, 4'd0}) begin errors++; $display("FAIL rmw_addr: got %h expected %h", {mc_rq_cyc, mc_rd_rq, mc_wr_rq, fmc_select, ma, sel}, {4'b1110, 15'o20, 4'd0}); end
        nclk(1);
        cmc_addr_ack = 1'b0; cmc_rd_rs = 1'b1; mb_in = 36'o5;
        checks++; if ({mc_rq_cyc, mc_rd_rq, mc_wr_rq} !== 3'b011) begin errors++; $display("FAIL rmw_rdwait: got %b expected 011", {mc_rq_cyc, mc_rd_rq, mc_wr_rq}); end
        nclk(1);
        cmc_rd_rs = 1'b0; mb_in = '0; wr_data = 36'o7;
        checks++; if ({rd_valid, rd_data} !== {1'b1, 36'o5}) begin errors++; $display("FAIL rmw_rd_valid: got %h expected %h", {rd_valid, rd_data}, {1'b1, 36'o5}); end
        for (int i = 3; i <= 9; i++) begin
            checks++; if ({busy, done, mc_rd_rq, mc_wr_rq, mc_wr_rs, mb_out} !== {5'b10110, 36'd0}) begin errors++; $display("FAIL rmw_hold_%0d: got %h expected %h", i, {busy, done, mc_rd_rq, mc_wr_rq, mc_wr_rs, mb_out}, {5'b10110, 36'd0}); end
            nclk(1);
        end
        wr_go = 1'b1; wr_data = 36'o6;
        nclk(1);
        wr_go = 1'b0; wr_data = 36'o7;
        for (int i = 11; i <= 16; i++) begin
            checks++; if ({mc_rd_rq, mc_wr_rq, mc_wr_rs, mb_out} !== {2'b11, (i >= 15), 36'o6}) begin errors++; $display("FAIL rmw_write_%0d: got %h expected %h", i, {mc_rd_rq, mc_wr_rq, mc_wr_rs, mb_out}, {2'b11, (i >= 15), 36'o6}); end
            nclk(1);
        end
        checks++; if ({done, mc_rd_rq, mc_wr_rq, mc_wr_rs, mb_out} !== {4'b1000, 36'd0}) begin errors++; $display("FAIL rmw_done: got %h expected %h", {done, mc_rd_rq, mc_wr_rq, mc_wr_rs, mb_out}, {4'b1000, 36'd0}); end
        nclk(1);
        checks++; if ({busy, rd_data} !== {1'b0, 36'o5}) begin errors++; $display("FAIL rmw_idle: got %h expected %h", {busy, rd_data}, {1'b0, 36'o5}); end
        checks++; if ({done_cnt - d0, rv_cnt - v0} !== {32'd1, 32'd1}) begin errors++; $display("FAIL rmw_pulse_counts: got done %0d valid %0d expected 1 1", done_cnt - d0, rv_cnt - v0); end
    endtask

    task automatic test_timeout_addr();
        int bad;
        bad = 0;
        rq_rd = 1'b1; rq_addr = 18'o000017;
        nclk(1);
        rq_rd = 1'b0;
        checks++; if ({fmc_select, ma, sel, nxm} !== {1'b1, 15'o17, 4'd0, 1'b0}) begin errors++; $display("FAIL nxm_addr: got %h expected %h", {fmc_select, ma, sel, nxm}, {1'b1, 15'o17, 4'd0, 1'b0}); end
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (mc_rq_cyc !== 1'b1 || done !== 1'b0) bad++;
            nclk(1);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL nxm_early: got %0d bad ADDR cycles expected 0", bad); end
        checks++; if ({done, nxm, mc_rq_cyc, mc_rd_rq, mb_out} !== {4'b1100, 36'd0}) begin errors++; $display("FAIL nxm_done: got %h expected %h", {done, nxm, mc_rq_cyc, mc_rd_rq, mb_out}, {4'b1100, 36'd0}); end
        nclk(1);
        checks++; if ({busy, nxm, mc_rq_cyc} !== 3'b010) begin errors++; $display("FAIL nxm_sticky: got %b expected 010", {busy, nxm, mc_rq_cyc}); end
    endtask

    task automatic test_timeout_rdwait();
        int bad, v0, w0;
        bad = 0; v0 = rv_cnt; w0 = wrrs_cnt;
        rq_rd = 1'b1; rq_wr = 1'b1; rq_addr = 18'o000100; wr_data = 36'o3;
        nclk(1);
        rq_rd = 1'b0; rq_wr = 1'b0; cmc_addr_ack = 1'b1;
        checks++; if (nxm !== 1'b0) begin errors++; $display("FAIL nxm_cleared: got %b expected 0", nxm); end
        nclk(1);
        cmc_addr_ack = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (mc_rd_rq !== 1'b1 || mc_rq_cyc !== 1'b0 || done !== 1'b0) bad++;
            nclk(1);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rdto_early: got %0d bad RDWAIT cycles expected 0", bad); end
        checks++; if ({done, nxm, mb_out} !== {2'b11, 36'd0}) begin errors++; $display("FAIL rdto_done: got %h expected %h", {done, nxm, mb_out}, {2'b11, 36'd0}); end
        nclk(1);
        checks++; if ({busy, rv_cnt - v0, wrrs_cnt - w0} !== {1'b0, 32'd0, 32'd0}) begin errors++; $display("FAIL rdto_no_write: got busy %b valid %0d wrrs %0d expected 0 0 0", busy, rv_cnt - v0, wrrs_cnt - w0); end
    endtask

    task automatic test_ack_at_timeout();
        rq_rd = 1'b1; rq_addr = 18'o000003;
        nclk(1);
        rq_rd = 1'b0;
        checks++; if (nxm !== 1'b0) begin errors++; $display("FAIL late_nxm_clear: got %b expected 0", nxm); end
        nclk(TIMEOUT - 1);
        checks++; if ({mc_rq_cyc, done} !== 2'b10) begin errors++; $display("FAIL late_still_addr: got %b expected 10", {mc_rq_cyc, done}); end
        cmc_addr_ack = 1'b1;
        nclk(1);
        cmc_addr_ack = 1'b0;
        checks++; if ({busy, done, nxm, mc_rq_cyc, mc_rd_rq} !== 5'b10001) begin errors++; $display("FAIL late_ack_wins: got %b expected 10001", {busy, done, nxm, mc_rq_cyc, mc_rd_rq}); end
        nclk(TIMEOUT - 1);
        cmc_rd_rs = 1'b1; mb_in = 36'o42;
        nclk(1);
        cmc_rd_rs = 1'b0; mb_in = '0;
        checks++; if ({done, rd_valid, nxm, rd_data} !== {3'b110, 36'o42}) begin errors++; $display("FAIL late_rs_wins: got %h expected %h", {done, rd_valid, nxm, rd_data}, {3'b110, 36'o42}); end
        nclk(1);
    endtask

    task automatic test_reset_wrrs();
        int d0;
        rq_wr = 1'b1; rq_addr = 18'o000200; wr_data = 36'o123; cmc_addr_ack = 1'b1;
        nclk(1);
        rq_wr = 1'b0;
        nclk(1);
        cmc_addr_ack = 1'b0;
        nclk(4);
        checks++; if ({mc_wr_rs, mb_out} !== {1'b1, 36'o123}) begin errors++; $display("FAIL rst_in_wrrs: got %h expected %h", {mc_wr_rs, mb_out}, {1'b1, 36'o123}); end
        d0 = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({busy, done, mc_wr_rs, mc_wr_rq, mb_out} !== {4'b0000, 36'd0}) begin errors++; $display("FAIL rst_async: got %h expected 0", {busy, done, mc_wr_rs, mc_wr_rq, mb_out}); end
        nclk(2);
        reset_n = 1'b1;
        nclk(1);
        checks++; if ({busy, done_cnt - d0} !== {1'b0, 32'd0}) begin errors++; $display("FAIL rst_no_done: got busy %b done %0d expected 0 0", busy, done_cnt - d0); end
        rq_rd = 1'b1; rq_addr = 18'o000400; cmc_addr_ack = 1'b1;
        nclk(1);
        rq_rd = 1'b0;
        nclk(1);
        cmc_addr_ack = 1'b0; cmc_rd_rs = 1'b1; mb_in = 36'o11;
        nclk(1);
        cmc_rd_rs = 1'b0; mb_in = '0;
        checks++; if ({done, rd_valid, nxm, rd_data} !== {3'b110, 36'o11}) begin errors++; $display("FAIL rst_resume_read: got %h expected %h", {done, rd_valid, nxm, rd_data}, {3'b110, 36'o11}); end
        nclk(1);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rst_resume_done: got %0d expected 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_read_or();
        test_write();
        test_rmw();
        test_timeout_addr();
        test_timeout_rdwait();
        test_ack_at_timeout();
        test_reset_wrrs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
